// File: rtl/pipe_issue_ctrl_if.sv
// Producer-side valid/ready bundle carrying one operand set
// (a,b,c,d) into the issue stage.
interface pipe_issue_ctrl_if #(
    parameter int W = 10
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] in_c;
    logic [W-1:0] in_d;

    modport master (
        output in_valid, in_a, in_b, in_c, in_d,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, in_d,
        output in_ready
    );
endinterface

// File: rtl/pipe_issue_ctrl.sv
// Issue stage for pipe_ex: operand FIFO, one issue per clock,
// fixed-latency tracking and tagged result capture.
module pipe_issue_ctrl #(
    parameter int W     = 10,
    parameter int DEPTH = 4,
    parameter int LAT   = 3,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    pipe_issue_ctrl_if.slave in_bus,
    input  logic            issue_en,
    output logic [W-1:0]    a_o,
    output logic [W-1:0]    b_o,
    output logic [W-1:0]    c_o,
    output logic [W-1:0]    d_o,
    output logic            issue,
    input  logic [W-1:0]    f_in,
    output logic [W-1:0]    res,
    output logic            res_valid,
    output logic            busy,
    output logic [CNTW-1:0] issued_cnt,
    output logic [CNTW-1:0] retired_cnt
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] d;
    } opset_t;

    opset_t          mem_q [DEPTH];
    opset_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     cnt_q, cnt_d;
    opset_t          ops_q, ops_d;
    logic            issue_q, issue_d;
    logic [LAT-1:0]  vld_q, vld_d;
    logic [W-1:0]    res_q, res_d;
    logic            res_valid_q, res_valid_d;
    logic [CNTW-1:0] issued_q, issued_d;
    logic [CNTW-1:0] retired_q, retired_d;

    logic full, empty, push, pop;

    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign push  = in_bus.in_valid & ~full;
    assign pop   = issue_en & ~empty;

    assign in_bus.in_ready = ~full;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{a: in_bus.in_a, b: in_bus.in_b,
                                c: in_bus.in_c, d: in_bus.in_d};
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Bubbles drive zeros so idle cycles are deterministic downstream.
    always_comb begin
        ops_d       = pop ? mem_q[rd_ptr_q] : '0;
        issue_d     = pop;
        issued_d    = issued_q + CNTW'(pop);
        vld_d       = LAT'({vld_q, issue_q});
        res_valid_d = vld_q[LAT-1];
        res_d       = vld_q[LAT-1] ? f_in : res_q;
        retired_d   = retired_q + CNTW'(vld_q[LAT-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ops_q       <= '0;
            issue_q     <= 1'b0;
            vld_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            issued_q    <= '0;
            retired_q   <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ops_q       <= ops_d;
            issue_q     <= issue_d;
            vld_q       <= vld_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            issued_q    <= issued_d;
            retired_q   <= retired_d;
        end
    end

    assign a_o         = ops_q.a;
    assign b_o         = ops_q.b;
    assign c_o         = ops_q.c;
    assign d_o         = ops_q.d;
    assign issue       = issue_q;
    assign res         = res_q;
    assign res_valid   = res_valid_q;
    assign issued_cnt  = issued_q;
    assign retired_cnt = retired_q;
    // The set on a_o..d_o this cycle counts as in flight.
    assign busy = ~empty | issue_q | (|vld_q) | res_valid_q;
endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl with a 3-stage pipe_ex stand-in,
// a queue-based reference model and directed scenarios.
module tb_pipe_issue_ctrl;
    localparam int W = 10;
    localparam int DEPTH = 4;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic issue_en = 1'b1;
    logic [W-1:0] a_o, b_o, c_o, d_o, f_in, res;
    logic issue, res_valid, busy;
    logic [15:0] issued_cnt, retired_cnt;

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;
    bit saw_ffff = 1'b0;

    pipe_issue_ctrl_if #(.W(W)) bus ();

    pipe_issue_ctrl #(.W(W), .DEPTH(DEPTH), .LAT(LAT), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_bus(bus.slave),
        .issue_en(issue_en),
        .a_o(a_o), .b_o(b_o), .c_o(c_o), .d_o(d_o),
        .issue(issue), .f_in(f_in), .res(res),
        .res_valid(res_valid), .busy(busy),
        .issued_cnt(issued_cnt), .retired_cnt(retired_cnt)
    );

    always #10 clk = ~clk;

    function automatic logic [W-1:0] pf(logic [W-1:0] a, b, c, d);
        return W'(a * b + c - d);
    endfunction

    // pipe_ex stand-in: f of operands driven in cycle N appears in N+LAT
    logic [W-1:0] pr [LAT];
    always @(posedge clk) begin
        pr[0] <= pf(a_o, b_o, c_o, d_o);
        for (int i = 1; i < LAT; i++) pr[i] <= pr[i-1];
    end
    assign f_in = pr[LAT-1];

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, each issued set scheduled to
    // retire LAT+1 edges later with f computed directly.
    typedef struct {
        int unsigned  due;
        logic [W-1:0] f;
    } pend_t;
    pend_t pend[$];
    logic [4*W-1:0] mfifo[$];
    int unsigned e = 0;
    logic [W-1:0] m_a, m_b, m_c, m_d, m_res;
    logic m_issue, m_rv;
    logic [15:0] m_ic, m_rc;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mfifo.delete();
            pend.delete();
            {m_a, m_b, m_c, m_d, m_res} = '0;
            m_issue = 1'b0;
            m_rv = 1'b0;
            m_ic = '0;
            m_rc = '0;
        end else begin
            bit pu, po;
            logic [4*W-1:0] s;
            e++;
            pu = bus.in_valid && mfifo.size() < DEPTH;
            po = issue_en && mfifo.size() > 0;
            if (po) begin
                s = mfifo.pop_front();
                {m_a, m_b, m_c, m_d} = s;
                m_issue = 1'b1;
                m_ic++;
                pend.push_back('{e + LAT + 1, pf(m_a, m_b, m_c, m_d)});
            end else begin
                {m_a, m_b, m_c, m_d} = '0;
                m_issue = 1'b0;
            end
            if (pu) mfifo.push_back({bus.in_a, bus.in_b, bus.in_c, bus.in_d});
            m_rv = 1'b0;
            if (pend.size() > 0 && pend[0].due == e) begin
                m_rv = 1'b1;
                m_res = pend[0].f;
                void'(pend.pop_front());
                m_rc++;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (cmp_on) begin
            chk("in_ready", bus.in_ready, mfifo.size() < DEPTH);
            chk("issue", issue, m_issue);
            chk("ops", {a_o, b_o, c_o, d_o}, {m_a, m_b, m_c, m_d});
            chk("res_valid", res_valid, m_rv);
            chk("res", res, m_res);
            chk("busy", busy, mfifo.size() > 0 || pend.size() > 0 || m_rv);
            chk("issued_cnt", issued_cnt, m_ic);
            chk("retired_cnt", retired_cnt, m_rc);
        end
    end

    initial forever begin
        @(negedge clk);
        if (issued_cnt == 16'hFFFF) saw_ffff = 1'b1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_set(input logic [W-1:0] a, b, c, d);
        bit acc;
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_d = d;
        do begin
            acc = bus.in_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("push_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_rv();
        int n = 0;
        while (!res_valid && n < 20) begin tick(); n++; end
        if (!res_valid) chk("rv_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin tick(); n++; end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        {bus.in_a, bus.in_b, bus.in_c, bus.in_d} = '0;
        repeat (3) tick();
        chk("rst_issue", issue, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_icnt", issued_cnt, 0);
        rst_n = 1'b1;
        cmp_on = 1'b1;
        tick();

        // single set
        push_set(5, 12, 6, 3);
        chk("t1_bubble", issue, 0);
        tick();
        chk("t1_issue", issue, 1);
        chk("t1_ops", {a_o, b_o, c_o, d_o}, {10'd5, 10'd12, 10'd6, 10'd3});
        repeat (3) begin tick(); chk("t1_norv", res_valid, 0); end
        tick();
        chk("t1_rv", res_valid, 1);
        chk("t1_res", res, 63);
        chk("t1_icnt", issued_cnt, 1);
        chk("t1_rcnt", retired_cnt, 1);
        tick();
        chk("t1_busy_fall", busy, 0);

        // back-to-back stream
        push_set(10, 8, 5, 2);
        push_set(20, 11, 1, 4);
        push_set(15, 10, 8, 2);
        chk("t2_iss2", {issue, a_o}, {1'b1, 10'd20});
        tick();
        chk("t2_iss3", {issue, a_o}, {1'b1, 10'd15});
        wait_rv();
        chk("t2_res0", res, 83);
        tick();
        chk("t2_res1", {res_valid, res}, {1'b1, 10'd217});
        tick();
        chk("t2_res2", {res_valid, res}, {1'b1, 10'd156});
        wait_idle();

        // issue_en held low, FIFO fills, then full+pop refusal
        issue_en = 1'b0;
        for (int i = 0; i < 4; i++) push_set(W'(100 + i), W'(i), W'(i), W'(i));
        bus.in_valid = 1'b1;
        bus.in_a = 104; bus.in_b = 4; bus.in_c = 4; bus.in_d = 4;
        chk("t3_full", bus.in_ready, 0);
        repeat (2) tick();
        chk("t3_hold", {bus.in_ready, issue}, 2'b00);
        issue_en = 1'b1;
        chk("t4_refuse", bus.in_ready, 0);
        tick();
        chk("t4_iss0", {issue, a_o}, {1'b1, 10'd100});
        chk("t4_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("t3_iss1", a_o, 101);
        tick();
        chk("t3_iss2", a_o, 102);
        tick();
        chk("t3_iss3", a_o, 103);
        tick();
        chk("t3_iss4", {issue, a_o}, {1'b1, 10'd104});
        wait_idle();

        // reset with two sets in flight
        push_set(7, 7, 7, 7);
        push_set(9, 9, 9, 9);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_zero", {issue, res_valid, busy, a_o, res}, '0);
        chk("t5_cnts", {issued_cnt, retired_cnt}, '0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (8) begin tick(); chk("t5_norv", res_valid, 0); end
        push_set(1, 1, 1, 1);
        wait_rv();
        chk("t5_res", res, 1);
        chk("t5_rcnt", retired_cnt, 1);
        wait_idle();

        // counter wrap: 65535 more issues brings both counters to 0
        for (int k = 0; k < 65535; k++)
            push_set(W'(k), W'(k >> 3), W'(k + 7), W'(k >> 1));
        begin
            int t = 0;
            int last = -100;
            while (busy && t < 40) begin
                tick();
                t++;
                if (res_valid) last = t;
            end
            chk("t6_busy_fall", t - last, 1);
        end
        chk("t6_saw_ffff", saw_ffff, 1);
        chk("t6_icnt", issued_cnt, 16'h0000);
        chk("t6_rcnt", retired_cnt, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
